// File: rtl/bandgap_pwr_seq_if.sv
// Client-side bundle for the bandgap sequencer: requests, grants, comparator flag and status.
interface bandgap_pwr_seq_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            bg_ok;
    logic            fault_clr;
    logic            bg_en;
    logic            ready;
    logic            fault;
    logic [2:0]      state;

    modport master (
        output req, bg_ok, fault_clr,
        input  ack, bg_en, ready, fault, state
    );

    modport slave (
        input  req, bg_ok, fault_clr,
        output ack, bg_en, ready, fault, state
    );
endinterface

// File: rtl/bandgap_pwr_seq.sv
// Bandgap reference power sequencer: enables the macro on demand, waits for settle
// and a good VBGP flag, grants requesters, and holds EN briefly after the last request.
module bandgap_pwr_seq #(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 4096,
    parameter int HOLD_CYC    = 256,
    parameter int CNT_W       = 13
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    bandgap_pwr_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_START = 3'd1,
        S_READY = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_M1  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_M1    = CNT_W'(HOLD_CYC - 1);

    state_t           st;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             ok_m;
    logic             ok_s;
    logic             anyreq;

    assign anyreq    = |bus.req;
    assign bus.state = st;

    always_comb begin
        nxt = st;
        case (st)
            S_OFF:   if (anyreq) nxt = S_START;
            S_START: begin
                if (!anyreq)                       nxt = S_OFF;
                else if (cnt >= SETTLE_M1 && ok_s) nxt = S_READY;
                else if (cnt == TIMEOUT_M1)        nxt = S_FAULT;
            end
            S_READY: begin
                if (!ok_s)        nxt = S_FAULT;
                else if (!anyreq) nxt = S_HOLD;
            end
            S_HOLD: begin
                if (anyreq)              nxt = S_READY;
                else if (cnt == HOLD_M1) nxt = S_OFF;
            end
            S_FAULT: if (bus.fault_clr) nxt = S_OFF;
            default: nxt = S_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            st        <= S_OFF;
            cnt       <= '0;
            ok_m      <= 1'b0;
            ok_s      <= 1'b0;
            bus.bg_en <= 1'b0;
            bus.ready <= 1'b0;
            bus.fault <= 1'b0;
            bus.ack   <= '0;
        end else begin
            ok_m <= bus.bg_ok;
            ok_s <= ok_m;
            st   <= nxt;
            if (nxt != st)
                cnt <= '0;
            else if ((st == S_START || st == S_HOLD) && cnt != '1)
                cnt <= cnt + 1'b1;
            bus.bg_en <= (nxt == S_START) || (nxt == S_READY) || (nxt == S_HOLD);
            bus.ready <= (nxt == S_READY) || (nxt == S_HOLD);
            bus.fault <= (nxt == S_FAULT);
            bus.ack   <= (st == S_READY && nxt == S_READY) ? bus.req : '0;
        end
    end
endmodule

// File: tb/tb_bandgap_pwr_seq.sv
// Directed bench for bandgap_pwr_seq with a per-cycle reference model and literal checkpoints.
module tb_bandgap_pwr_seq;
    localparam int NREQ    = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 32;
    localparam int HOLD    = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bandgap_pwr_seq_if #(.NREQ(NREQ)) bus ();

    bandgap_pwr_seq #(
        .NREQ(NREQ), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT),
        .HOLD_CYC(HOLD), .CNT_W(6)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode numbers 0 off, 1 start, 2 ready, 3 hold, 4 fault.
    // age = edges spent in the current mode; ok_d1/ok_d2 = bg_ok seen one/two edges ago.
    int              m_mode;
    int              m_age;
    logic            ok_d1;
    logic            ok_d2;
    logic [NREQ-1:0] m_ack;

    function automatic int next_mode(input int mode, input int age, input logic ok,
                                     input logic [NREQ-1:0] r, input logic clr);
        bit any = (r != 0);
        case (mode)
            0: return any ? 1 : 0;
            1: begin
                if (!any) return 0;
                if (age + 1 >= SETTLE && ok) return 2;
                if (age + 1 == TIMEOUT) return 4;
                return 1;
            end
            2: return !ok ? 4 : (any ? 2 : 3);
            3: return any ? 2 : ((age + 1 == HOLD) ? 0 : 3);
            4: return clr ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_age  <= 0;
            ok_d1  <= 1'b0;
            ok_d2  <= 1'b0;
            m_ack  <= '0;
        end else begin
            m_mode <= next_mode(m_mode, m_age, ok_d2, bus.req, bus.fault_clr);
            m_age  <= (next_mode(m_mode, m_age, ok_d2, bus.req, bus.fault_clr) != m_mode) ? 0 : m_age + 1;
            m_ack  <= (m_mode == 2 && next_mode(m_mode, m_age, ok_d2, bus.req, bus.fault_clr) == 2)
                      ? bus.req : '0;
            ok_d1  <= bus.bg_ok;
            ok_d2  <= ok_d1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_state", 32'(bus.state), 32'(m_mode));
            chk("model_bg_en", 32'(bus.bg_en), 32'(m_mode >= 1 && m_mode <= 3));
            chk("model_ready", 32'(bus.ready), 32'(m_mode == 2 || m_mode == 3));
            chk("model_fault", 32'(bus.fault), 32'(m_mode == 4));
            chk("model_ack",   32'(bus.ack),   32'(m_ack));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req       = '0;
        bus.bg_ok     = 1'b1;
        bus.fault_clr = 1'b0;
        tick(2);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_bg_en", 32'(bus.bg_en), 0);
        chk("rst_ack",   32'(bus.ack),   0);
        chk("rst_fault", 32'(bus.fault), 0);
        rst = 1'b0;
        tick(3);

        // Nominal startup
        bus.req = 4'b0001;
        tick(1);
        chk("nom_bg_en_t1", 32'(bus.bg_en), 1);
        chk("nom_start",    32'(bus.state), 1);
        tick(7);
        chk("nom_still_start_t8", 32'(bus.state), 1);
        tick(1);
        chk("nom_ready_t9", 32'(bus.state), 2);
        chk("nom_rdy_t9",   32'(bus.ready), 1);
        chk("nom_ack_t9",   32'(bus.ack),   0);
        tick(1);
        chk("nom_ack_t10",  32'(bus.ack),   4'b0001);

        // Hold-off then re-request without settle
        bus.req = '0;
        tick(1);
        chk("hold_state", 32'(bus.state), 3);
        chk("hold_ack",   32'(bus.ack),   0);
        tick(1);
        bus.req = 4'b0001;
        tick(1);
        chk("rereq_state", 32'(bus.state), 2);
        tick(1);
        chk("rereq_ack", 32'(bus.ack), 4'b0001);

        // Hold expiry
        bus.req = '0;
        tick(4);
        chk("hold_last_cycle", 32'(bus.state), 3);
        tick(1);
        chk("hold_exp_state", 32'(bus.state), 0);
        chk("hold_exp_bg_en", 32'(bus.bg_en), 0);

        // Multi-client
        bus.req = 4'b0011;
        tick(10);
        chk("mc_ack_0011", 32'(bus.ack), 4'b0011);
        bus.req = 4'b0010;
        tick(1);
        chk("mc_ack_0010",   32'(bus.ack),   4'b0010);
        chk("mc_still_rdy",  32'(bus.state), 2);
        bus.req = '0;
        tick(1);
        chk("mc_hold", 32'(bus.state), 3);
        tick(4);

        // Brown-out in READY
        bus.req = 4'b0001;
        tick(10);
        chk("bo_ack_before", 32'(bus.ack), 4'b0001);
        bus.bg_ok = 1'b0;
        tick(2);
        chk("bo_lag", 32'(bus.state), 2);
        tick(1);
        chk("bo_state", 32'(bus.state), 4);
        chk("bo_ack",   32'(bus.ack),   0);
        chk("bo_ready", 32'(bus.ready), 0);
        tick(3);
        chk("fault_sticky", 32'(bus.state), 4);

        // Clear, then timeout with bg_ok low, with a stray fault_clr in START
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("clr_off",   32'(bus.state), 0);
        chk("clr_fault", 32'(bus.fault), 0);
        tick(1);
        chk("clr_restart", 32'(bus.state), 1);
        tick(10);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("stray_clr_ignored", 32'(bus.state), 1);
        tick(20);
        chk("to_not_yet", 32'(bus.state), 1);
        tick(1);
        chk("to_state", 32'(bus.state), 4);
        chk("to_fault", 32'(bus.fault), 1);
        chk("to_bg_en", 32'(bus.bg_en), 0);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("to_clr_off", 32'(bus.state), 0);
        tick(1);
        chk("to_clr_start", 32'(bus.state), 1);
        bus.req = '0;
        tick(1);
        chk("abort_state", 32'(bus.state), 0);
        chk("abort_bg_en", 32'(bus.bg_en), 0);

        // Async reset mid-START
        bus.bg_ok = 1'b1;
        bus.req   = 4'b0100;
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("arst_bg_en", 32'(bus.bg_en), 0);
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_ack",   32'(bus.ack),   0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("post_rst_start", 32'(bus.state), 1);
        tick(12);
        chk("post_rst_ack", 32'(bus.ack), 4'b0100);

        bus.req = '0;
        tick(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
